// File: rtl/demux_i1_x4_pkg.sv
// demux_i1_x4_pkg
//   Shared definitions for the registered 1-to-4 demultiplexer:
//   default word width, channel encodings, slot state encoding and the
//   channel-to-one-hot load decoder.
package demux_i1_x4_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   localparam logic [1:0] CH0 = 2'b00;
   localparam logic [1:0] CH1 = 2'b01;
   localparam logic [1:0] CH2 = 2'b10;
   localparam logic [1:0] CH3 = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   // One-hot select of the slot addressed by a channel number.
   function automatic logic [3:0] ch_decode(input logic [1:0] ch);
      logic [3:0] sel;
      sel = 4'b0000;
      case (ch)
         CH0:     sel = 4'b0001;
         CH1:     sel = 4'b0010;
         CH2:     sel = 4'b0100;
         CH3:     sel = 4'b1000;
         default: sel = 4'b0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry output buffer with a two-state EMPTY/FULL FSM.
//   Ports:
//     i_clk, i_rst  clock, synchronous active-high reset
//     i_load        write i_data into the slot this cycle
//     i_drain       consumer takes the slot contents this cycle (ignored when EMPTY)
//     i_data        word to store
//     o_can_load    slot can take a word this cycle (EMPTY, or FULL and draining)
//     o_valid       slot holds a word
//     o_data        stored word; holds its last value after draining
//     o_state       current FSM state (debug / checker visibility)
module demux_slot
   import demux_i1_x4_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic                  i_drain,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_can_load,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output slot_state_t           o_state
);

   slot_state_t state;
   slot_state_t state_nxt;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= EMPTY;
      else       state <= state_nxt;
   end

   // Next-state logic: a load always wins over a drain, so a slot that is
   // drained and reloaded in the same cycle stays FULL with no bubble.
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (i_load) state_nxt = FULL;
         FULL:    if (i_drain && !i_load) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Outputs
   always_comb begin
      o_valid    = (state == FULL);
      o_can_load = (state == EMPTY) || i_drain;
      o_state    = state;
   end

   // Data register is not cleared on drain; consumers qualify with o_valid.
   always_ff @(posedge i_clk) begin
      if (i_rst)       o_data <= '0;
      else if (i_load) o_data <= i_data;
   end

endmodule

// File: rtl/demux_i1_x4.sv
// demux_i1_x4
//   Registered 1-to-4 demultiplexer. A producer word is steered by i_control
//   into one of four independent one-entry slots, each drained by its own
//   consumer.
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_valid, o_ready    producer handshake
//     i_control           destination channel 0..3
//     i_data              producer word
//     o_valid[n], i_ready[n]  consumer n handshake
//     o_data0..o_data3    slot contents
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. The producer holds i_valid/i_control/i_data stable until
//   accepted; o_ready depends only on i_control, slot state and i_ready,
//   never on i_valid or i_data.
module demux_i1_x4
   import demux_i1_x4_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [1:0]            i_control,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [3:0]            o_valid,
   input  logic [3:0]            i_ready,
   output logic [DATA_WIDTH-1:0] o_data0,
   output logic [DATA_WIDTH-1:0] o_data1,
   output logic [DATA_WIDTH-1:0] o_data2,
   output logic [DATA_WIDTH-1:0] o_data3
);

   logic [3:0]            can_load;
   logic [3:0]            slot_valid;
   logic [3:0]            load;
   logic [DATA_WIDTH-1:0] slot_data [4];
   slot_state_t           slot_state [4];
   logic                  accept;

   always_comb begin
      o_ready = can_load[i_control];
      accept  = i_valid && o_ready;
      load    = accept ? ch_decode(i_control) : 4'b0000;
   end

   for (genvar n = 0; n < 4; n++) begin : g_slot
      demux_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_load     (load[n]),
         .i_drain    (i_ready[n]),
         .i_data     (i_data),
         .o_can_load (can_load[n]),
         .o_valid    (slot_valid[n]),
         .o_data     (slot_data[n]),
         .o_state    (slot_state[n])
      );
      // o_valid is taken from the exposed FSM state so checkers on either
      // signal see the same thing.
      assign o_valid[n] = (slot_state[n] == FULL) && slot_valid[n];
   end

   assign o_data0 = slot_data[0];
   assign o_data1 = slot_data[1];
   assign o_data2 = slot_data[2];
   assign o_data3 = slot_data[3];

endmodule

// File: doc/demux_i1_x4.md
# demux_i1_x4

Registered 1-to-4 demultiplexer with valid/ready handshaking on both sides, the routing counterpart of the 4:1 datapath mux. A single producer presents a word plus a 2-bit destination; the block steers it into one of four one-entry output slots, each drained independently by its own consumer. It sits on the MIPS core result/memory-return path, fanning one bus out to up to four sinks without stalling unrelated sinks.

## Interface
- DATA_WIDTH, 32, width of data words
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous reset, active-high
- i_valid  input  1  producer has a word on i_data
- o_ready  output  1  block accepts the word this cycle
- i_control  input  2  destination channel, 2'b00..2'b11 → channel 0..3
- i_data  input  DATA_WIDTH  input word
- o_valid  output  4  bit n: channel n slot holds a word
- i_ready  input  4  bit n: consumer n takes the word this cycle
- o_data0, o_data1, o_data2, o_data3  output  DATA_WIDTH each  channel slot contents

## Operation
- Four independent slots; each is a two-state FSM: EMPTY (o_valid[n]=0) / FULL (o_valid[n]=1).
- Accept: o_ready = (slot[i_control] EMPTY) or (i_ready[i_control]=1). Transfer occurs when i_valid & o_ready.
- On accept, slot[i_control] loads i_data and goes/stays FULL.
- Drain: a FULL slot n with i_ready[n]=1 transfers out; it goes EMPTY unless it is reloaded in the same cycle.
- Simultaneous drain and load of the same slot: slot reloaded with new word, o_valid[n] stays 1, no bubble.
- Load of one slot and drain of another in the same cycle: both take effect independently.
- i_control and i_data are don't-care while i_valid=0; no state changes.
- i_valid & !o_ready: nothing is loaded; producer must hold i_valid, i_control and i_data stable until accepted.
- o_data[n] holds its last loaded value after draining (it is not cleared); consumers qualify it with o_valid[n].
- i_ready[n] while slot n EMPTY: ignored.
- Words are never duplicated, dropped, or sent to a channel other than i_control at accept time.

## Timing
- Reset (i_rst=1 at a clock edge): all slots EMPTY, o_valid=4'b0000, o_data0..3 = 0. Takes priority over simultaneous load/drain; in-flight slot contents are discarded.
- o_ready is combinational from i_control, slot state and i_ready; no combinational path from i_data to any output.
- Latency: word accepted at edge k appears on o_data[n] with o_valid[n]=1 after edge k (visible in cycle k+1).
- Throughput: one word per cycle sustained to a single channel when its consumer holds i_ready=1; one word per cycle round-robin across channels regardless of consumer readiness until the target slot is FULL and not draining.
- First cycle after reset release: o_ready=1 for any i_control.

## Structure
- Shared package: DATA_WIDTH default; channel encoding constants CH0=2'b00, CH1=2'b01, CH2=2'b10, CH3=2'b11; slot state encoding EMPTY/FULL.
- One sub-module: demux_slot (one-entry buffer with load/drain, valid flag, data register, sync reset), instantiated four times; top level holds the 2→4 load decoder and o_ready mux.

## Test plan
- Reset: hold i_rst 2 cycles with i_valid=1, i_data=32'hDEADBEEF → o_valid=4'b0000, all o_data*=0, no load; first cycle after release o_ready=1.
- Single routing: i_control=2'b10, i_data=32'h0000_00A5, i_ready=4'b0000 → next cycle o_valid=4'b0100, o_data2=32'hA5, other channels unchanged.
- Backpressure: channel 1 FULL with i_ready[1]=0, send to channel 1 → o_ready=0, o_data1 unchanged; raise i_ready[1] → o_ready=1, word accepted, o_valid[1] stays 1 with new data.
- Full-rate stream: i_ready=4'b1111, send 32'h1,2,3,4 on consecutive cycles to channel 3 → o_ready=1 every cycle, o_data3 shows 1,2,3,4 on consecutive cycles, no bubbles.
- Independent channels: channel 0 FULL and stalled (i_ready[0]=0), send 32'h55 to channel 2 → accepted, o_valid=4'b0101; channel 0 content intact.
- Reset mid-operation: all four slots FULL, assert i_rst same cycle as i_valid to channel 1 and i_ready=4'b1111 → next cycle o_valid=4'b0000, all o_data*=0.
